// File: rtl/div_sqrt_ctrl_pkg.sv
// div_sqrt_ctrl_pkg: shared widths and FSM state type for the mantissa divider
package div_sqrt_ctrl_pkg;
    localparam int C_MANT_W = 24;
    localparam int C_ITER   = 26;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/div_mant_addsub.sv
// div_mant_addsub: shared add/sub path, subtraction done as r2 + ~b + 1
module div_mant_addsub #(
    parameter int W  = 26,
    parameter int BW = 24
) (
    input  logic [W-1:0]  r2,
    input  logic [BW-1:0] b,
    input  logic          sub,
    output logic [W-1:0]  sum,
    output logic          carry
);
    logic [W-1:0] op;
    assign op = sub ? ~{{(W-BW){1'b0}}, b} : {{(W-BW){1'b0}}, b};
    assign {carry, sum} = {1'b0, r2} + {1'b0, op} + {{W{1'b0}}, sub};
endmodule

// File: rtl/div_mant_iter_ctrl.sv
// div_mant_iter_ctrl: non-restoring mantissa divider, one quotient digit per cycle
module div_mant_iter_ctrl
    import div_sqrt_ctrl_pkg::*;
#(
    parameter int MANT_W = C_MANT_W,
    parameter int ITER   = C_ITER
) (
    input  logic              Clk_CI,
    input  logic              Rst_RI,
    input  logic              Div_start_SI,
    input  logic              Kill_SI,
    input  logic [MANT_W-1:0] Mant_a_DI,
    input  logic [MANT_W-1:0] Mant_b_DI,
    output logic              Ready_SO,
    output logic              Done_SO,
    output logic [ITER-1:0]   Quot_DO,
    output logic              Sticky_SO
);
    localparam int RW = MANT_W + 2;
    localparam int CW = $clog2(ITER + 1);

    state_t            state, state_nxt;
    logic [RW-1:0]     r_q, r2, sum, neg_b;
    logic [MANT_W-1:0] b_q, b_op;
    logic [ITER-1:0]   quot_q;
    logic [CW-1:0]     cnt_q;
    logic              sticky_q, sub, start, last, carry_unused;

    assign start = state == IDLE && Div_start_SI && !Kill_SI;
    assign last  = state == RUN && cnt_q == CW'(ITER - 1);
    // The first step (A - B) reuses the iteration adder with A as its operand
    assign r2    = state == IDLE ? {2'b00, Mant_a_DI} : {r_q[RW-2:0], 1'b0};
    assign b_op  = state == IDLE ? Mant_b_DI : b_q;
    assign sub   = state == IDLE || !r_q[RW-1];
    assign neg_b = ~{2'b00, b_q} + RW'(1);

    div_mant_addsub #(.W(RW), .BW(MANT_W)) u_addsub (
        .r2    (r2),
        .b     (b_op),
        .sub   (sub),
        .sum   (sum),
        .carry (carry_unused)
    );

    // Next state: kill always wins, DONE lasts one cycle
    always_comb begin
        state_nxt = Kill_SI ? IDLE :
                    state == IDLE ? (Div_start_SI ? RUN : IDLE) :
                    state == RUN  ? (last ? DONE : RUN) : IDLE;
    end

    // State register
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath: load on start, iterate in RUN, freeze otherwise or on kill
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            r_q      <= '0;
            b_q      <= '0;
            quot_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else if (!Kill_SI && (start || state == RUN)) begin
            r_q    <= sum;
            quot_q <= start ? {{(ITER-1){1'b0}}, ~sum[RW-1]} : {quot_q[ITER-2:0], ~sum[RW-1]};
            cnt_q  <= start ? CW'(1) : cnt_q + CW'(1);
            if (start) b_q <= Mant_b_DI;
            if (last) sticky_q <= sum != '0 && sum != neg_b;
        end
    end

    assign Ready_SO  = state == IDLE;
    assign Done_SO   = state == DONE;
    assign Quot_DO   = quot_q;
    assign Sticky_SO = sticky_q;
endmodule

// File: tb/tb_div_mant_iter_ctrl.sv
// tb_div_mant_iter_ctrl: directed and random checks against a quotient/remainder model
module tb_div_mant_iter_ctrl;
    localparam int MW = 24;
    localparam int IT = 26;

    logic          clk = 1'b0, rst = 1'b1;
    logic          start = 1'b0, kill = 1'b0;
    logic [MW-1:0] a = '0, b = '0;
    logic          ready, done, sticky;
    logic [IT-1:0] quot;
    int            total = 0, passed = 0, cyc = 0, ndone = 0;

    // Model state: 0 idle, 1 busy, 2 done
    int            phase = 0, left = 0, hold = 1;
    logic [IT-1:0] m_q = '0;
    logic          m_s = 1'b0;
    logic [MW-1:0] m_a, m_b;

    div_mant_iter_ctrl dut (
        .Clk_CI       (clk),
        .Rst_RI       (rst),
        .Div_start_SI (start),
        .Kill_SI      (kill),
        .Mant_a_DI    (a),
        .Mant_b_DI    (b),
        .Ready_SO     (ready),
        .Done_SO      (done),
        .Quot_DO      (quot),
        .Sticky_SO    (sticky)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) ndone++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        else passed++;
    endtask

    // Exact quotient floor(A*2^(IT-1)/B) and nonzero-remainder flag
    task automatic ref_div(input logic [MW-1:0] x, input logic [MW-1:0] y, output logic [IT-1:0] q, output logic s);
        longint n;
        n = longint'(x) << (IT - 1);
        q = IT'(n / longint'(y));
        s = (n % longint'(y)) != 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase = 0; hold = 1; m_q = '0; m_s = 1'b0;
        end else if (kill) begin
            phase = 0;
        end else if (phase == 0) begin
            if (start) begin phase = 1; left = IT - 1; m_a = a; m_b = b; hold = 0; end
        end else if (phase == 1) begin
            left--;
            if (left == 0) begin phase = 2; ref_div(m_a, m_b, m_q, m_s); hold = 1; end
        end else phase = 0;
    end

    always @(negedge clk) begin
        chk("ready", ready, phase == 0);
        chk("done", done, phase == 2);
        if (hold != 0) begin
            chk("quot", quot, m_q);
            chk("sticky", sticky, m_s);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic go(input logic [MW-1:0] x, input logic [MW-1:0] y, output int ts);
        a = x; b = y; start = 1'b1; ts = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int ts, input logic [IT-1:0] eq, input logic es);
        repeat (60) begin
            @(negedge clk);
            if (done) break;
        end
        chk({nm, "_latency"}, cyc - ts, IT);
        chk({nm, "_quot"}, quot, eq);
        chk({nm, "_sticky"}, sticky, es);
        tick();
    endtask

    initial begin
        int t, n0;
        #1;
        chk("reset_quot", quot, 0);
        chk("reset_ready", ready, 1);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        go(24'h800000, 24'h800000, t); wait_done("one", t, 26'h2000000, 1'b0);
        go(24'hC00000, 24'h800000, t); wait_done("1p5", t, 26'h3000000, 1'b0);
        go(24'h800000, 24'hC00000, t); wait_done("2_3", t, 26'h1555555, 1'b1);
        go(24'hFFFFFF, 24'h800000, t); wait_done("max", t, 26'h3FFFFFC, 1'b0);
        go(24'h900000, 24'hA00000, t);
        repeat (3) tick();
        a = 24'hFFFFFF; b = 24'h800000; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("restart_ignored", t, 26'h1CCCCCC, 1'b1);
        go(24'hC00000, 24'h800000, t);
        repeat (9) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("kill_ready", ready, 1);
        go(24'h800000, 24'hC00000, t); wait_done("after_kill", t, 26'h1555555, 1'b1);
        n0 = ndone;
        go(24'h800000, 24'h800000, t);
        repeat (24) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        repeat (3) tick();
        chk("kill_last_no_done", ndone - n0, 0);
        go(24'hC00000, 24'h800000, t);
        repeat (7) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", ready, 1);
        chk("arst_done", done, 0);
        chk("arst_quot", quot, 0);
        chk("arst_sticky", sticky, 0);
        n0 = ndone;
        tick();
        rst = 1'b0;
        repeat (30) tick();
        chk("arst_no_done", ndone - n0, 0);
        repeat (1500) begin
            start = ($urandom % 4) == 0;
            kill  = ($urandom % 50) == 0;
            a = MW'($urandom_range(24'h800000, 24'hFFFFFF));
            b = MW'($urandom_range(24'h800000, 24'hFFFFFF));
            tick();
        end
        start = 1'b0; kill = 1'b0;
        repeat (30) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/div_mant_iter_ctrl.md
DIV_MANT_ITER_CTRL -- requirements
Module: div_mant_iter_ctrl

Interface
REQ-001 SHALL have parameter MANT_W, default 24, meaning mantissa width including the hidden bit.
REQ-002 SHALL have parameter ITER, default 26, meaning quotient digits produced (MANT_W + guard + round).
REQ-003 SHALL have port Clk_CI  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port Rst_RI  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port Div_start_SI  in  1  start request; accepted only while Ready_SO=1.
REQ-006 SHALL have port Kill_SI  in  1  abort the current operation.
REQ-007 SHALL have port Mant_a_DI  in  MANT_W  dividend mantissa, unsigned, hidden bit at MSB.
REQ-008 SHALL have port Mant_b_DI  in  MANT_W  divisor mantissa, unsigned, hidden bit at MSB.
REQ-009 SHALL have port Ready_SO  out  1  high in IDLE only.
REQ-010 SHALL have port Done_SO  out  1  one-cycle result-valid pulse.
REQ-011 SHALL have port Quot_DO  out  ITER  quotient; bit ITER-1 has weight 2^0.
REQ-012 SHALL have port Sticky_SO  out  1  high when the true remainder is nonzero.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL hold partial remainder R as a signed register of MANT_W+2 bits and divisor B as a MANT_W register.
REQ-015 In IDLE, on Div_start_SI=1 and Kill_SI=0: latch B, set R = A - B, set Quot = {ITER-1 zeros, ~sign(R)}, set cnt = 1, and go to RUN.
REQ-016 In RUN, each cycle: R = 2R - B if sign(R)=0, else R = 2R + B; Quot = {Quot[ITER-2:0], ~sign(new R)}; cnt = cnt + 1.
REQ-017 RUN SHALL go to DONE on the edge where cnt reaches ITER, so RUN lasts exactly ITER-1 cycles.
REQ-018 Latency: start accepted in cycle T gives Done_SO=1 in cycle T+ITER, for exactly one cycle; DONE then returns to IDLE.
REQ-019 Subtraction SHALL be performed as R + ~B + 1 through a single shared add/sub path with carry-in; the operand is selected by sign(R).
REQ-020 Sticky_SO SHALL be registered on entry to DONE and set when R_final != 0 and R_final != -B (corrected remainder nonzero).
REQ-021 Quot_DO and Sticky_SO SHALL hold their values from DONE until the next accepted start.
REQ-022 Div_start_SI SHALL be ignored in RUN and DONE.
REQ-023 Kill_SI=1 in any state SHALL force IDLE on the next edge with no Done_SO pulse; Kill_SI SHALL win over a simultaneous Div_start_SI.
REQ-024 Kill_SI in the same cycle as the final RUN edge SHALL suppress DONE.
REQ-025 The block SHALL NOT check input normalization; results follow the arithmetic of REQ-015 to REQ-020 for any input.
REQ-026 cnt width SHALL be clog2(ITER+1); cnt SHALL never wrap.

Reset
REQ-027 Rst_RI=1 SHALL asynchronously force IDLE, with R, B, Quot, cnt and Sticky all zero.
REQ-028 During and after reset, Ready_SO=1, Done_SO=0, Quot_DO=0 and Sticky_SO=0.
REQ-029 Reset mid-RUN SHALL discard the operation with no Done_SO pulse.

Structure
REQ-030 Package div_sqrt_ctrl_pkg SHALL hold C_MANT_W, C_ITER and the FSM state enum.
REQ-031 The add/sub path SHALL be one sub-module, div_mant_addsub: inputs 2R, B, and a Sub select; outputs sum and carry.
REQ-032 All other logic SHALL be in div_mant_iter_ctrl.

Verification
REQ-033 A=0x800000, B=0x800000 -> Done at T+26, Quot=0x2000000, Sticky=0.
REQ-034 A=0xC00000, B=0x800000 -> Quot=0x3000000, Sticky=0.
REQ-035 A=0x800000, B=0xC00000 -> Quot=0x1555555, Sticky=1.
REQ-036 Start pulsed again at T+5 during RUN -> ignored; Done at T+26 with the first operands' result.
REQ-037 Kill_SI at T+10 -> Ready_SO=1 at T+11 and no Done_SO; a new start at T+11 completes at T+37.
REQ-038 Rst_RI asserted asynchronously mid-RUN -> all outputs immediately at reset values and no Done_SO afterwards.
